// File: rtl/hvsync_pkg.sv
// Default 640x480@60 timing constants, 10-bit coordinate type and sync polarity helper.
`default_nettype none

package hvsync_pkg;

   localparam int unsigned COORD_W       = 10;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef logic [COORD_W-1:0] coord_t;

   // Pin level for a sync pulse: active_low inverts the active flag.
   function automatic logic sync_level(input logic active, input logic active_low);
      return active ^ active_low;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hvsync_wrap_counter.sv
// 10-bit counter with enable that wraps to 0 after TERMINAL; reports terminal count and wrap.
`default_nettype none

module hvsync_wrap_counter
   import hvsync_pkg::*;
#(
   parameter coord_t TERMINAL = coord_t'(DEF_H_TOTAL - 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   output logic [COORD_W-1:0] count,
   output logic               tc,
   output logic               wrap
);

   assign tc   = (count == TERMINAL);
   assign wrap = en && tc;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hv_sync_generator.sv
// VGA raster timing generator: registered pixel/line counters plus combinational sync/visible decode.
// Optional HVSYNC_FRAME_PULSE_EN adds a one-cycle frame_start output at (0,0).
`default_nettype none

module hv_sync_generator
   import hvsync_pkg::*;
#(
   parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT         = DEF_H_FRONT,
   parameter int unsigned H_SYNC          = DEF_H_SYNC,
   parameter int unsigned H_BACK          = DEF_H_BACK,
   parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT         = DEF_V_FRONT,
   parameter int unsigned V_SYNC          = DEF_V_SYNC,
   parameter int unsigned V_BACK          = DEF_V_BACK,
   parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic [COORD_W-1:0] counterX,
   output logic [COORD_W-1:0] counterY,
   output logic               vga_h_sync,
   output logic               vga_v_sync,
   output logic               inDisplayArea
`ifdef HVSYNC_FRAME_PULSE_EN
   ,
   output logic               frame_start
`endif
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
   localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic   ACT_LOW   = (SYNC_ACTIVE_LOW != 0);

   logic h_tc, h_wrap, v_tc, v_wrap;
   logic hs_active, vs_active;

   hvsync_wrap_counter #(
      .TERMINAL (coord_t'(H_TOTAL - 1))
   ) u_h_counter (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .count (counterX),
      .tc    (h_tc),
      .wrap  (h_wrap)
   );

   // Lines advance only on the cycle the pixel counter wraps.
   hvsync_wrap_counter #(
      .TERMINAL (coord_t'(V_TOTAL - 1))
   ) u_v_counter (
      .clk   (clk),
      .reset (reset),
      .en    (h_wrap),
      .count (counterY),
      .tc    (v_tc),
      .wrap  (v_wrap)
   );

   logic unused_flags;
   assign unused_flags = &{1'b0, h_tc, v_tc, v_wrap};

   assign hs_active     = (counterX >= HS_START) && (counterX < HS_END);
   assign vs_active     = (counterY >= VS_START) && (counterY < VS_END);
   assign vga_h_sync    = sync_level(hs_active, ACT_LOW);
   assign vga_v_sync    = sync_level(vs_active, ACT_LOW);
   assign inDisplayArea = (counterX < H_VIS_END) && (counterY < V_VIS_END);

`ifdef HVSYNC_FRAME_PULSE_EN
   assign frame_start = !reset && (counterX == '0) && (counterY == '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hv_sync_generator.sv
// Directed self-checking bench: default 640x480 instance plus a tiny active-high-sync instance for full frames.
`default_nettype none

module tb_hv_sync_generator;

   logic       clk;
   logic       reset;
   logic [9:0] x0, y0, x1, y1;
   logic       hs0, vs0, de0, hs1, vs1, de1;
`ifdef HVSYNC_FRAME_PULSE_EN
   logic       fs0, fs1;
`endif

   int checks = 0;
   int errors = 0;

   hv_sync_generator dut0 (
      .clk           (clk),
      .reset         (reset),
      .counterX      (x0),
      .counterY      (y0),
      .vga_h_sync    (hs0),
      .vga_v_sync    (vs0),
      .inDisplayArea (de0)
`ifdef HVSYNC_FRAME_PULSE_EN
      ,
      .frame_start   (fs0)
`endif
   );

   // Small raster: H 8+2+3+2=15, V 6+1+2+2=11, frame 165 clocks, sync active high.
   hv_sync_generator #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .SYNC_ACTIVE_LOW(0)
   ) dut1 (
      .clk           (clk),
      .reset         (reset),
      .counterX      (x1),
      .counterY      (y1),
      .vga_h_sync    (hs1),
      .vga_v_sync    (vs1),
      .inDisplayArea (de1)
`ifdef HVSYNC_FRAME_PULSE_EN
      ,
      .frame_start   (fs1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int hs_cnt, hs_first, hs_last, de_fall, saw_last, n;
      int cyc, vs_cnt, hs1_cnt, de_cnt, vs_x, vs_y, max_x, max_y, fs_cnt;

      reset = 1'b1;
      step(); step(); step();
      chk("rst_x", x0, 0);
      chk("rst_y", y0, 0);
      chk("rst_hs", hs0, 1);
      chk("rst_vs", vs0, 1);
      chk("rst_de", de0, 1);
`ifdef HVSYNC_FRAME_PULSE_EN
      chk("rst_fs", fs0, 0);
`endif
      reset = 1'b0;
      #1;
      chk("rel_x", x0, 0);
`ifdef HVSYNC_FRAME_PULSE_EN
      chk("rel_fs", fs0, 1);
`endif
      step();
      chk("first_x", x0, 1);
      chk("first_y", y0, 0);

      // One line of the default raster.
      hs_cnt = 0; hs_first = -1; hs_last = -1; de_fall = -1; saw_last = 0;
      n = 0;
      while (x0 != 10'd0 && n < 2000) begin
         if (hs0 == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(x0);
            hs_last = int'(x0);
         end
         if (de0 == 1'b0 && de_fall < 0) de_fall = int'(x0);
         if (x0 == 10'd799) saw_last = 1;
         step();
         n++;
      end
      chk("line_bound", n, 799);
      chk("hs_len", hs_cnt, 96);
      chk("hs_first", hs_first, 656);
      chk("hs_last", hs_last, 751);
      chk("de_fall", de_fall, 640);
      chk("x_max799", saw_last, 1);
      chk("y_inc", y0, 1);

      // Reset mid-frame at (300,1).
      n = 0;
      while (x0 != 10'd300 && n < 1000) begin
         step();
         n++;
      end
      chk("reach_300", x0, 300);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_x", x0, 0);
      chk("mid_y", y0, 0);
      chk("mid_hs", hs0, 1);
      chk("mid_vs", vs0, 1);
      chk("mid_x1", x1, 0);
      chk("mid_y1", y1, 0);
      chk("idle_hs1", hs1, 0);
      chk("idle_vs1", vs1, 0);

      // Full frame of the small raster from (0,0) back to (0,0).
      cyc = 0; vs_cnt = 0; hs1_cnt = 0; de_cnt = 0; vs_x = -1; vs_y = -1;
      max_x = 0; max_y = 0; fs_cnt = 0;
      do begin
         if (vs1) begin
            vs_cnt++;
            if (vs_x < 0) begin vs_x = int'(x1); vs_y = int'(y1); end
         end
         if (hs1) hs1_cnt++;
         if (de1) de_cnt++;
         if (int'(x1) > max_x) max_x = int'(x1);
         if (int'(y1) > max_y) max_y = int'(y1);
`ifdef HVSYNC_FRAME_PULSE_EN
         if (fs1) fs_cnt++;
`endif
         step();
         cyc++;
      end while (!(x1 == 10'd0 && y1 == 10'd0) && cyc < 400);
      chk("frame_len", cyc, 165);
      chk("vs_len", vs_cnt, 30);
      chk("vs_start_x", vs_x, 0);
      chk("vs_start_y", vs_y, 7);
      chk("hs_total", hs1_cnt, 33);
      chk("de_total", de_cnt, 48);
      chk("x1_max", max_x, 14);
      chk("y1_max", max_y, 10);
`ifdef HVSYNC_FRAME_PULSE_EN
      chk("fs_per_frame", fs_cnt, 1);
      chk("fs_next", fs1, 1);
`endif
      chk("x0_after", x0, 165);
      chk("y0_after", y0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
